ysyx_mc_ctrl: RTL and testbench
===============================

# ysyx_mc_ctrl

Multi-cycle sequencer for the ysyx RV32 core. It replaces the divided-clock single-cycle scheme with an explicit FSM on `clk`. The FSM owns the PC and the instruction register, and issues valid/ready requests to an instruction port (IFU) and a load/store port (LSU). It emits single-cycle write-enable pulses to the register file and CSR file, and stops on `ebreak` or on a bus error. It sits between the combinational decode/ALU datapath and the memory bus.

## Interface
Parameters:
- WIDTH, 32, datapath/address width
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- TIMEOUT, 255, maximum cycles spent in any request or wait state; range 1..65535

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- ifu_req_valid  out  1  fetch request
- ifu_req_addr  out  WIDTH  fetch address (= pc)
- ifu_req_ready  in  1  IFU accepts request
- ifu_rsp_valid  in  1  fetch data valid
- ifu_rsp_data  in  32  fetched instruction
- lsu_req_valid  out  1  load/store request
- lsu_req_we  out  1  1 = store
- lsu_req_op  out  3  funct3 size/sign code
- lsu_req_addr  out  WIDTH  effective address
- lsu_req_wdata  out  WIDTH  store data
- lsu_req_ready  in  1  LSU accepts request
- lsu_rsp_valid  in  1  load data valid, or store acknowledge
- lsu_rsp_rdata  in  WIDTH  load data
- dec_is_load, dec_is_store, dec_rd_we, dec_csr_we, dec_is_ebreak  in  1 each  decode of `inst`
- dec_mem_op  in  3  funct3 from decode
- alu_result  in  WIDTH  effective address, or ALU writeback value
- rs2_data  in  WIDTH  store data
- next_pc  in  WIDTH  next PC computed by the datapath
- pc  out  WIDTH  current PC
- inst  out  32  instruction register
- load_data  out  WIDTH  latched load result
- rf_we  out  1  register-file write pulse
- csr_we  out  1  CSR write pulse
- commit  out  1  instruction-retired pulse
- halted  out  1  sticky; set by ebreak
- bus_err  out  1  sticky error flag
- err_code  out  2  01 fetch timeout, 10 LSU timeout, 11 misaligned fetch
- mcycle, minstret  out  64 each  performance counters

## Operation
- States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERR.
- **FETCH_REQ**
  - If `pc[1:0]!=0`, go to ERR with code 11; no request is issued.
  - Otherwise assert `ifu_req_valid`. When `ifu_req_ready` is 1, go to FETCH_WAIT.
- **FETCH_WAIT:** on `ifu_rsp_valid`, latch `inst <= ifu_rsp_data` and go to EXEC.
- **EXEC:** one cycle for decode/ALU to settle.
  - If load or store: latch `alu_result`, `rs2_data`, `dec_mem_op` and `dec_is_store` into the LSU request registers, then go to MEM_REQ.
  - Otherwise go to WB.
- **MEM_REQ:** assert `lsu_req_valid` with the latched fields. On `lsu_req_ready`, go to MEM_WAIT.
- **MEM_WAIT:** on `lsu_rsp_valid`, go to WB. For a load, first latch `load_data <= lsu_rsp_rdata`.
- **WB:** single cycle.
  - Pulse `rf_we = dec_rd_we`, `csr_we = dec_csr_we`, `commit = 1`.
  - Update `pc <= next_pc`.
  - If `dec_is_ebreak`: set `halted`, go to HALT, and leave `pc` unchanged.
  - Otherwise go to FETCH_REQ.
- **HALT and ERR:** terminal until `rst`. No requests issued, no pulses emitted.
- **Timeout:** a 16-bit wait counter clears on every state change and increments in FETCH_REQ, FETCH_WAIT, MEM_REQ and MEM_WAIT. When it reaches TIMEOUT, go to ERR with code 01 (fetch states) or 10 (LSU states). A response or ready in that same cycle is ignored.
- **Ignored inputs:**
  - `rsp_valid` outside its own WAIT state.
  - `ifu_rsp_valid` asserted in the same cycle as `ifu_req_ready`.
- **Request-field stability:** `lsu_req_*` and `ifu_req_addr` are driven from registers and hold stable while valid is high.

## Timing
- **Reset:**
  - State = FETCH_REQ, `pc = RESET_PC`.
  - `inst`, `load_data` = 0.
  - All valids, pulses, `halted`, `bus_err`, `err_code`, counters = 0.
  - An in-flight transaction is abandoned; a late response after reset is ignored until the FSM is in the matching WAIT state.
- **Latency with zero-wait bus** (ready tied 1, response the cycle after acceptance):
  - Non-memory instruction: 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB).
  - Load/store: 6 cycles.
- **Pulse timing:** `rf_we`, `csr_we` and `commit` are high exactly one cycle, in WB. The new `pc` is visible the cycle after WB.
- **Datapath inputs:** `dec_*`, `next_pc` and `alu_result` are sampled only in EXEC and WB. The datapath must hold them stable from EXEC through WB; `inst` and the register file do not change in between.

## Configuration
- Macro: `YSYX_MC_PERF_EN`.
- **Defined:**
  - `mcycle` increments every cycle out of reset, including HALT and ERR.
  - `minstret` increments on each `commit`.
  - Both counters wrap at 2^64.
- **Undefined:** `mcycle` and `minstret` are tied to 0 and no counter flops exist. Ports are present either way.

## Test plan
- **Reset:** `rst` high for 2 cycles -> `pc=32'h8000_0000`, `ifu_req_valid=1` in the first cycle after reset, all pulses 0.
- **Back-to-back ALU instructions:** zero-wait IFU, `next_pc=pc+4`, three `addi` -> `commit` every 4th cycle, `pc` reaches 32'h8000_000C, `rf_we` high 3 cycles total.
- **Load:** load with `alu_result=32'h8000_0100`, LSU ready delayed 3 cycles, `rdata=32'hDEAD_BEEF` -> `lsu_req_addr` stable for all 4 valid cycles, `load_data=32'hDEAD_BEEF`, `rf_we` pulses once.
- **Store:** store with `rs2_data=32'h1234_5678`, `op=3'b010` -> `lsu_req_we=1`, `lsu_req_wdata=32'h1234_5678`, WB only after `lsu_rsp_valid`.
- **Timeout:** `TIMEOUT=8`, IFU never responds -> ERR with `bus_err=1`, `err_code=01` after 8 cycles in FETCH_WAIT, no further requests. A misaligned `next_pc=32'h8000_0002` -> `err_code=11`.
- **ebreak and perf counters:** `ebreak` -> `halted=1`, `commit` pulses once, `pc` unchanged. With `YSYX_MC_PERF_EN`, `minstret` equals the commit count and `mcycle` equals cycles since reset.

Source files
------------

// File: rtl/ysyx_mc_ctrl.sv
// Multi-cycle sequencer for the ysyx RV32 core: owns PC/IR and drives IFU/LSU valid-ready handshakes.
// Define YSYX_MC_PERF_EN to build the mcycle/minstret performance counters.
module ysyx_mc_ctrl #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000),
  parameter int unsigned      TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  output logic [WIDTH-1:0] ifu_req_addr,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  input  logic [31:0]      ifu_rsp_data,
  output logic             lsu_req_valid,
  output logic             lsu_req_we,
  output logic [2:0]       lsu_req_op,
  output logic [WIDTH-1:0] lsu_req_addr,
  output logic [WIDTH-1:0] lsu_req_wdata,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  input  logic [WIDTH-1:0] lsu_rsp_rdata,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_rd_we,
  input  logic             dec_csr_we,
  input  logic             dec_is_ebreak,
  input  logic [2:0]       dec_mem_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] pc,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] load_data,
  output logic             rf_we,
  output logic             csr_we,
  output logic             commit,
  output logic             halted,
  output logic             bus_err,
  output logic [1:0]       err_code,
  output logic [63:0]      mcycle,
  output logic [63:0]      minstret
);
  localparam int unsigned      CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_FETCH_TO = 2'b01;
  localparam logic [1:0] ERR_LSU_TO   = 2'b10;
  localparam logic [1:0] ERR_MISALIGN = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH_REQ, S_FETCH_WAIT, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_WB, S_HALT, S_ERR
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             cnt_en;
  logic             timeout;
  logic [1:0]       err_nxt;

  assign ifu_req_addr = pc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH_REQ;
    else     state <= state_nxt;
  end

  // Next-state, handshake and writeback pulses; timeout wins over a same-cycle ready/response
  always_comb begin
    state_nxt     = state;
    err_nxt       = 2'b00;
    cnt_en        = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rf_we         = 1'b0;
    csr_we        = 1'b0;
    commit        = 1'b0;
    timeout       = (wait_cnt == CNT_LAST);
    case (state)
      S_FETCH_REQ: begin
        if (pc[1:0] != 2'b00) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_MISALIGN;
        end else begin
          ifu_req_valid = 1'b1;
          cnt_en        = 1'b1;
          if (timeout) begin
            state_nxt = S_ERR;
            err_nxt   = ERR_FETCH_TO;
          end else if (ifu_req_ready) begin
            state_nxt = S_FETCH_WAIT;
          end
        end
      end
      S_FETCH_WAIT: begin
        cnt_en = 1'b1;
        if (timeout) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_FETCH_TO;
        end else if (ifu_rsp_valid) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: state_nxt = (dec_is_load || dec_is_store) ? S_MEM_REQ : S_WB;
      S_MEM_REQ: begin
        lsu_req_valid = 1'b1;
        cnt_en        = 1'b1;
        if (timeout) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_LSU_TO;
        end else if (lsu_req_ready) begin
          state_nxt = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        cnt_en = 1'b1;
        if (timeout) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_LSU_TO;
        end else if (lsu_rsp_valid) begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        rf_we     = dec_rd_we;
        csr_we    = dec_csr_we;
        commit    = 1'b1;
        state_nxt = dec_is_ebreak ? S_HALT : S_FETCH_REQ;
      end
      S_HALT:  state_nxt = S_HALT;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // Wait counter, PC/IR, LSU request fields and sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt      <= '0;
      pc            <= RESET_PC;
      inst          <= '0;
      load_data     <= '0;
      lsu_req_we    <= 1'b0;
      lsu_req_op    <= '0;
      lsu_req_addr  <= '0;
      lsu_req_wdata <= '0;
      halted        <= 1'b0;
      bus_err       <= 1'b0;
      err_code      <= '0;
    end else begin
      if (state_nxt != state) wait_cnt <= '0;
      else if (cnt_en)        wait_cnt <= wait_cnt + CNT_W'(1);

      if (state == S_FETCH_WAIT && state_nxt == S_EXEC) inst <= ifu_rsp_data;

      if (state == S_EXEC && state_nxt == S_MEM_REQ) begin
        lsu_req_we    <= dec_is_store;
        lsu_req_op    <= dec_mem_op;
        lsu_req_addr  <= alu_result;
        lsu_req_wdata <= rs2_data;
      end

      if (state == S_MEM_WAIT && state_nxt == S_WB && !lsu_req_we) load_data <= lsu_rsp_rdata;

      if (state == S_WB) begin
        if (dec_is_ebreak) halted <= 1'b1;
        else               pc     <= next_pc;
      end

      if (state_nxt == S_ERR && state != S_ERR) begin
        bus_err  <= 1'b1;
        err_code <= err_nxt;
      end
    end
  end

`ifdef YSYX_MC_PERF_EN
  // Free-running cycle and retire counters, wrapping at 2^64
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle <= mcycle + 64'd1;
      if (commit) minstret <= minstret + 64'd1;
    end
  end
`else
  assign mcycle   = '0;
  assign minstret = '0;
`endif

endmodule

// File: tb/tb_ysyx_mc_ctrl.sv
// Self-checking bench for ysyx_mc_ctrl: a bus/datapath driver plus a cycle-count and state model.
// Honours YSYX_MC_PERF_EN for the expected counter values.
module tb_ysyx_mc_ctrl;
  localparam int          TO       = 8;
  localparam logic [31:0] RST_PC   = 32'h8000_0000;
  localparam int          K_ALU    = 0;
  localparam int          K_LOAD   = 1;
  localparam int          K_STORE  = 2;
  localparam int          K_EBREAK = 3;

  logic        clk, rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_req_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid;
  logic [2:0]  lsu_req_op;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
  logic        dec_is_load, dec_is_store, dec_rd_we, dec_csr_we, dec_is_ebreak;
  logic [2:0]  dec_mem_op;
  logic [31:0] alu_result, rs2_data, next_pc, pc, inst, load_data;
  logic        rf_we, csr_we, commit, halted, bus_err;
  logic [1:0]  err_code;
  logic [63:0] mcycle, minstret;

  ysyx_mc_ctrl #(.WIDTH(32), .RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we), .lsu_req_op(lsu_req_op),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_rd_we(dec_rd_we),
    .dec_csr_we(dec_csr_we), .dec_is_ebreak(dec_is_ebreak), .dec_mem_op(dec_mem_op),
    .alu_result(alu_result), .rs2_data(rs2_data), .next_pc(next_pc),
    .pc(pc), .inst(inst), .load_data(load_data), .rf_we(rf_we), .csr_we(csr_we),
    .commit(commit), .halted(halted), .bus_err(bus_err), .err_code(err_code),
    .mcycle(mcycle), .minstret(minstret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mpc;
  logic [31:0] m_ld;
  logic [63:0] m_ret;
  logic [63:0] tb_cyc;

  // Reference cycle count since reset release
  always @(posedge clk) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 64'd1;
  end

  int obs_cycles, obs_err_cycle, obs_rf, obs_csr, obs_ifu_vcyc, obs_lsu_vcyc;
  bit obs_ifu_ok, obs_lsu_ok, obs_early;

  task automatic apply_reset();
    rst = 1'b1;
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_data = '0;
    lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_rdata = '0;
    dec_is_load = 0; dec_is_store = 0; dec_rd_we = 0; dec_csr_we = 0; dec_is_ebreak = 0;
    dec_mem_op = '0; alu_result = '0; rs2_data = '0; next_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mpc = RST_PC; m_ld = '0; m_ret = '0;
  endtask

  // Plays IFU, LSU and datapath for one instruction; entered and left at a negedge.
  // Responses outside the WAIT phase carry random junk that must be ignored.
  task automatic drive_instr(input int kind, input int ird, input int irsp, input int lrd, input int lrsp,
                             input logic [31:0] iw, input logic [31:0] ea, input logic [31:0] wd,
                             input logic [31:0] rd, input logic [2:0] op, input logic rdwe,
                             input logic csrwe, input logic [31:0] npc);
    int fph, lph, ic, rw, lc, lw;
    bit done, is_mem;
    fph = 0; lph = 0; ic = 0; rw = 0; lc = 0; lw = 0; done = 0;
    is_mem = (kind == K_LOAD) || (kind == K_STORE);
    obs_cycles = 0; obs_err_cycle = -1; obs_rf = 0; obs_csr = 0; obs_ifu_vcyc = 0; obs_lsu_vcyc = 0;
    obs_ifu_ok = 1; obs_lsu_ok = 1; obs_early = 0;
    dec_is_load = (kind == K_LOAD); dec_is_store = (kind == K_STORE); dec_is_ebreak = (kind == K_EBREAK);
    dec_rd_we = rdwe; dec_csr_we = csrwe; dec_mem_op = op;
    alu_result = ea; rs2_data = wd; next_pc = npc;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      ifu_req_ready = 0; lsu_req_ready = 0;
      ifu_rsp_valid = 1'($urandom_range(0, 1)); ifu_rsp_data = $urandom;
      lsu_rsp_valid = 1'($urandom_range(0, 1)); lsu_rsp_rdata = $urandom;
      if (bus_err) begin
        obs_err_cycle = cyc; done = 1;
      end else begin
        if (rf_we)  obs_rf++;
        if (csr_we) obs_csr++;
        if (commit) begin
          obs_cycles = cyc + 1; done = 1;
          if (is_mem && lph != 2) obs_early = 1;
        end
        if (fph == 1) begin
          ifu_rsp_valid = (rw == irsp);
          if (rw == irsp) begin ifu_rsp_data = iw; fph = 2; end
          rw++;
        end else if (fph == 0 && ifu_req_valid) begin
          obs_ifu_vcyc++;
          if (ifu_req_addr !== mpc) obs_ifu_ok = 0;
          if (ic == ird) begin ifu_req_ready = 1; fph = 1; end
          ic++;
        end
        if (lph == 1) begin
          lsu_rsp_valid = (lw == lrsp);
          if (lw == lrsp) begin lsu_rsp_rdata = rd; lph = 2; end
          lw++;
        end else if (lph == 0 && lsu_req_valid) begin
          obs_lsu_vcyc++;
          if (lsu_req_addr !== ea || lsu_req_wdata !== wd || lsu_req_op !== op ||
              lsu_req_we !== (kind == K_STORE)) obs_lsu_ok = 0;
          if (lc == lrd) begin lsu_req_ready = 1; lph = 1; end
          lc++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (pc !== RST_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RST_PC); end
    checks++; if (ifu_req_valid !== 1'b1 || ifu_req_addr !== RST_PC) begin
      failures++; $display("FAIL reset_fetch valid=%b addr=%h exp valid=1 addr=%h", ifu_req_valid, ifu_req_addr, RST_PC); end
    checks++; if ({rf_we, csr_we, commit, lsu_req_valid} !== 4'b0) begin
      failures++; $display("FAIL reset_pulses got=%b exp=0000", {rf_we, csr_we, commit, lsu_req_valid}); end
    checks++; if ({halted, bus_err, err_code} !== 4'b0) begin
      failures++; $display("FAIL reset_status got=%b exp=0000", {halted, bus_err, err_code}); end
    checks++; if (inst !== 32'h0 || load_data !== 32'h0) begin
      failures++; $display("FAIL reset_regs inst=%h load_data=%h exp 0", inst, load_data); end
    checks++; if (mcycle !== 64'h0 || minstret !== 64'h0) begin
      failures++; $display("FAIL reset_counters mcycle=%0d minstret=%0d exp 0", mcycle, minstret); end
  endtask

  task automatic test_back_to_back();
    int rf_total;
    apply_reset();
    rf_total = 0;
    for (int i = 0; i < 3; i++) begin
      drive_instr(K_ALU, 0, 0, 0, 0, 32'h0010_0093 + 32'(i << 7), '0, '0, '0, 3'b000, 1'b1, 1'b0, mpc + 32'd4);
      rf_total += obs_rf;
      checks++; if (obs_cycles !== 4) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=4", i, obs_cycles); end
      mpc = mpc + 32'd4; m_ret++;
    end
    checks++; if (pc !== 32'h8000_000C) begin failures++; $display("FAIL b2b_pc got=%h exp=8000000c", pc); end
    checks++; if (rf_total !== 3) begin failures++; $display("FAIL b2b_rf_we got=%0d exp=3", rf_total); end
  endtask

  task automatic test_load();
    drive_instr(K_LOAD, 0, 0, 3, 0, 32'h0000_2083, 32'h8000_0100, 32'h5555_0000, 32'hDEAD_BEEF, 3'b010, 1'b1, 1'b0, mpc + 32'd4);
    mpc = mpc + 32'd4; m_ret++; m_ld = 32'hDEAD_BEEF;
    checks++; if (obs_lsu_vcyc !== 4 || !obs_lsu_ok) begin
      failures++; $display("FAIL load_req valid_cycles=%0d stable=%0b exp 4/1", obs_lsu_vcyc, obs_lsu_ok); end
    checks++; if (load_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_data got=%h exp=deadbeef", load_data); end
    checks++; if (obs_rf !== 1 || obs_cycles !== 9) begin
      failures++; $display("FAIL load_wb rf=%0d cycles=%0d exp 1/9", obs_rf, obs_cycles); end
  endtask

  task automatic test_store();
    drive_instr(K_STORE, 1, 0, 0, 2, 32'h0020_2023, 32'h8000_0200, 32'h1234_5678, '0, 3'b010, 1'b0, 1'b0, mpc + 32'd4);
    mpc = mpc + 32'd4; m_ret++;
    checks++; if (!obs_lsu_ok || obs_lsu_vcyc !== 1) begin
      failures++; $display("FAIL store_req fields_ok=%0b valid_cycles=%0d exp 1/1", obs_lsu_ok, obs_lsu_vcyc); end
    checks++; if (obs_early || obs_cycles !== 9 || obs_rf !== 0) begin
      failures++; $display("FAIL store_wb early=%0b cycles=%0d rf=%0d exp 0/9/0", obs_early, obs_cycles, obs_rf); end
    checks++; if (load_data !== m_ld) begin failures++; $display("FAIL store_load_data got=%h exp=%h", load_data, m_ld); end
  endtask

  task automatic test_random_mix();
    int kind, ird, irsp, lrd, lrsp, exp_cyc, exp_lv;
    logic [31:0] iw, ea, wd, rd, npc;
    logic rdwe, csrwe;
    logic [63:0] exp_mc, exp_ir;
    for (int n = 0; n < 25; n++) begin
      kind = $urandom_range(K_ALU, K_STORE);
      ird = $urandom_range(0, 3); irsp = $urandom_range(0, 3);
      lrd = $urandom_range(0, 3); lrsp = $urandom_range(0, 3);
      iw = $urandom; ea = $urandom; wd = $urandom; rd = $urandom;
      rdwe = (kind == K_STORE) ? 1'b0 : 1'($urandom_range(0, 1));
      csrwe = (kind == K_ALU) ? 1'($urandom_range(0, 1)) : 1'b0;
      npc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : mpc + 32'd4;
      drive_instr(kind, ird, irsp, lrd, lrsp, iw, ea, wd, rd, 3'($urandom_range(0, 7)) & 3'b111, rdwe, csrwe, npc);
      exp_cyc = 4 + ird + irsp + ((kind == K_ALU) ? 0 : 2 + lrd + lrsp);
      exp_lv  = (kind == K_ALU) ? 0 : lrd + 1;
      if (kind == K_LOAD) m_ld = rd;
      mpc = npc; m_ret++;
      checks++; if (obs_cycles !== exp_cyc) begin failures++; $display("FAIL mix_latency[%0d] got=%0d exp=%0d", n, obs_cycles, exp_cyc); end
      checks++; if (obs_rf !== int'(rdwe) || obs_csr !== int'(csrwe)) begin
        failures++; $display("FAIL mix_pulses[%0d] rf=%0d csr=%0d exp %0d/%0d", n, obs_rf, obs_csr, rdwe, csrwe); end
      checks++; if (inst !== iw || pc !== mpc) begin
        failures++; $display("FAIL mix_state[%0d] inst=%h pc=%h exp %h/%h", n, inst, pc, iw, mpc); end
      checks++; if (load_data !== m_ld) begin failures++; $display("FAIL mix_load_data[%0d] got=%h exp=%h", n, load_data, m_ld); end
      checks++; if (obs_lsu_vcyc !== exp_lv || !obs_lsu_ok || !obs_ifu_ok || obs_early) begin
        failures++; $display("FAIL mix_bus[%0d] lsu_valid=%0d exp=%0d lsu_ok=%0b ifu_ok=%0b early=%0b", n, obs_lsu_vcyc, exp_lv, obs_lsu_ok, obs_ifu_ok, obs_early); end
    end
`ifdef YSYX_MC_PERF_EN
    exp_mc = tb_cyc; exp_ir = m_ret;
`else
    exp_mc = '0; exp_ir = '0;
`endif
    checks++; if (mcycle !== exp_mc || minstret !== exp_ir) begin
      failures++; $display("FAIL mix_perf mcycle=%0d minstret=%0d exp %0d/%0d", mcycle, minstret, exp_mc, exp_ir); end
  endtask

  task automatic test_timeout();
    int t_kind[4] = '{K_ALU, K_ALU, K_LOAD, K_STORE};
    int t_ird[4]  = '{0, TO - 1, 0, 0};
    int t_irsp[4] = '{1000, 0, 0, 0};
    int t_lrd[4]  = '{0, 0, 1000, 0};
    int t_lrsp[4] = '{0, 0, 0, 1000};
    int t_cyc[4]  = '{1 + TO, TO, 3 + TO, 4 + TO};
    int t_code[4] = '{1, 1, 2, 2};
    bit bad;
    logic [31:0] p0;
    for (int i = 0; i < 4; i++) begin
      apply_reset();
      drive_instr(t_kind[i], t_ird[i], t_irsp[i], t_lrd[i], t_lrsp[i], $urandom, $urandom, $urandom, $urandom, 3'b010, 1'b1, 1'b0, mpc + 32'd4);
      checks++; if (obs_err_cycle !== t_cyc[i] || err_code !== 2'(t_code[i]) || bus_err !== 1'b1) begin
        failures++; $display("FAIL timeout[%0d] err_cycle=%0d code=%b bus_err=%b exp %0d/%b/1", i, obs_err_cycle, err_code, bus_err, t_cyc[i], 2'(t_code[i])); end
      bad = 0; p0 = pc;
      for (int k = 0; k < 10; k++) begin
        ifu_req_ready = 1; lsu_req_ready = 1; ifu_rsp_valid = 1; lsu_rsp_valid = 1;
        @(negedge clk);
        if (ifu_req_valid || lsu_req_valid || commit || rf_we || csr_we || pc !== p0 || err_code !== 2'(t_code[i])) bad = 1;
      end
      checks++; if (bad) begin failures++; $display("FAIL timeout_terminal[%0d] got=activity exp=quiet", i); end
    end
    apply_reset();
    drive_instr(K_ALU, TO - 2, TO - 2, 0, 0, 32'h0000_0013, '0, '0, '0, 3'b000, 1'b0, 1'b0, mpc + 32'd4);
    checks++; if (obs_cycles !== 2 * TO || bus_err !== 1'b0) begin
      failures++; $display("FAIL timeout_edge_ok cycles=%0d bus_err=%b exp %0d/0", obs_cycles, bus_err, 2 * TO); end
  endtask

  task automatic test_misaligned();
    apply_reset();
    drive_instr(K_ALU, 0, 0, 0, 0, 32'h0000_0013, '0, '0, '0, 3'b000, 1'b0, 1'b0, 32'h8000_0002);
    mpc = 32'h8000_0002;
    drive_instr(K_ALU, 0, 0, 0, 0, 32'h0000_0013, '0, '0, '0, 3'b000, 1'b0, 1'b0, mpc + 32'd4);
    checks++; if (obs_err_cycle !== 1 || obs_ifu_vcyc !== 0 || err_code !== 2'b11) begin
      failures++; $display("FAIL misaligned err_cycle=%0d fetch_reqs=%0d code=%b exp 1/0/11", obs_err_cycle, obs_ifu_vcyc, err_code); end
  endtask

  task automatic test_ebreak();
    bit bad;
    logic [63:0] exp_mc, exp_ir;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      drive_instr(K_ALU, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, $urandom, '0, '0, '0, 3'b000, 1'b1, 1'b0, mpc + 32'd4);
      mpc = mpc + 32'd4; m_ret++;
    end
    drive_instr(K_EBREAK, 1, 2, 0, 0, 32'h0010_0073, '0, '0, '0, 3'b000, 1'b0, 1'b1, mpc + 32'd4);
    m_ret++;
    checks++; if (obs_cycles !== 7 || obs_csr !== 1) begin
      failures++; $display("FAIL ebreak_commit cycles=%0d csr=%0d exp 7/1", obs_cycles, obs_csr); end
    checks++; if (halted !== 1'b1 || pc !== mpc) begin
      failures++; $display("FAIL ebreak_halt halted=%b pc=%h exp 1/%h", halted, pc, mpc); end
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      ifu_req_ready = 1; lsu_req_ready = 1; ifu_rsp_valid = 1; lsu_rsp_valid = 1;
      @(negedge clk);
      if (ifu_req_valid || lsu_req_valid || commit || rf_we || csr_we || pc !== mpc || halted !== 1'b1) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL ebreak_terminal got=activity exp=quiet"); end
`ifdef YSYX_MC_PERF_EN
    exp_mc = tb_cyc; exp_ir = m_ret;
`else
    exp_mc = '0; exp_ir = '0;
`endif
    checks++; if (mcycle !== exp_mc || minstret !== exp_ir) begin
      failures++; $display("FAIL ebreak_perf mcycle=%0d minstret=%0d exp %0d/%0d", mcycle, minstret, exp_mc, exp_ir); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_load();
    test_store();
    test_random_mix();
    test_timeout();
    test_misaligned();
    test_ebreak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
